// File: rtl/hazard_scoreboard.sv
// In-flight destination scoreboard that raises a decode stall on RAW hazards.
// Define HAZARD_FORWARD_EN to stall only on load-use; by default every match stalls.
module hazard_scoreboard #(
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [ADDR_W-1:0] src1,
  input  logic [ADDR_W-1:0] src2,
  input  logic              two_src,
  input  logic [ADDR_W-1:0] id_dest,
  input  logic              id_wb_en,
  input  logic              id_mem_read,
  output logic              hazard_detected,
  output logic              pending,
  output logic [15:0]       stall_count
);

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] dest;
    logic              mem_read;
  } entry_t;

  entry_t            r_ent [DEPTH];
  logic [15:0]       r_stall_count;
  logic [DEPTH-1:0]  w_match;
  logic              w_hazard;
  logic              w_insert;
  logic              w_pending;

  always_comb begin
    w_match   = '0;
    w_pending = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      w_match[k] = r_ent[k].valid &
                   ((src1 == r_ent[k].dest) | (two_src & (src2 == r_ent[k].dest)));
      w_pending  = w_pending | r_ent[k].valid;
    end
  end

`ifdef HAZARD_FORWARD_EN
  // Forwarding covers ALU results; only a load one stage ahead must stall.
  assign w_hazard = id_valid & ~flush & w_match[0] & r_ent[0].mem_read;
`else
  assign w_hazard = id_valid & ~flush & (|w_match);
`endif

  // Register 0 is never recorded, so it can never produce a match.
  assign w_insert = id_valid & id_wb_en & ~w_hazard & (id_dest != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) r_ent[k] <= '0;
      r_stall_count <= 16'd0;
    end else begin
      if (w_hazard && (r_stall_count != 16'hFFFF))
        r_stall_count <= r_stall_count + 16'd1;
      if (flush) begin
        for (int k = 0; k < DEPTH; k++) r_ent[k] <= '0;
      end else begin
        r_ent[0] <= '{valid: w_insert, dest: id_dest, mem_read: id_mem_read};
        for (int k = 1; k < DEPTH; k++) r_ent[k] <= r_ent[k-1];
      end
    end
  end

  assign hazard_detected = w_hazard;
  assign pending         = w_pending;
  assign stall_count     = r_stall_count;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: DEPTH=2 and DEPTH=8 instances share one stimulus
// stream and are checked against an age-based model through expected queues.
module tb_hazard_scoreboard;

`ifdef HAZARD_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, flush, id_valid, two_src, id_wb_en, id_mem_read;
  logic [4:0] src1, src2, id_dest;
  logic       haz0, pend0, haz1, pend1;
  logic [15:0] cnt0, cnt1;

  always #5 clk = ~clk;

  hazard_scoreboard #(.ADDR_W(5), .DEPTH(2)) u_d2 (
    .clk(clk), .rst(rst), .flush(flush), .id_valid(id_valid),
    .src1(src1), .src2(src2), .two_src(two_src), .id_dest(id_dest),
    .id_wb_en(id_wb_en), .id_mem_read(id_mem_read),
    .hazard_detected(haz0), .pending(pend0), .stall_count(cnt0));

  hazard_scoreboard #(.ADDR_W(5), .DEPTH(8)) u_d8 (
    .clk(clk), .rst(rst), .flush(flush), .id_valid(id_valid),
    .src1(src1), .src2(src2), .two_src(two_src), .id_dest(id_dest),
    .id_wb_en(id_wb_en), .id_mem_read(id_mem_read),
    .hazard_detected(haz1), .pending(pend1), .stall_count(cnt1));

  // Model: each issued writer is a record with its age in cycles since issue.
  typedef struct {
    int       inst;
    logic [4:0] dest;
    bit       load;
    int       age;
  } ifl_t;

  ifl_t        ifl_q[$];
  int unsigned m_cnt[2];
  logic [17:0] exp_q0[$];
  logic [17:0] exp_q1[$];
  int          n_vec = 0;
  int          n_miss = 0;

  function automatic int depth_of(input int inst);
    return (inst == 0) ? 2 : 8;
  endfunction

  task automatic model_step(input int inst, output logic [17:0] e);
    bit hit, haz, pend;
    hit  = 0;
    pend = 0;
    foreach (ifl_q[i]) begin
      if (ifl_q[i].inst == inst) begin
        pend = 1;
        if ((src1 == ifl_q[i].dest) || (two_src && (src2 == ifl_q[i].dest))) begin
          if (!FWD) hit = 1;
          else if (ifl_q[i].age == 0 && ifl_q[i].load) hit = 1;
        end
      end
    end
    haz = id_valid && !flush && hit;
    e = {haz, pend, 16'(m_cnt[inst])};
    if (rst) begin
      m_cnt[inst] = 0;
      for (int i = ifl_q.size() - 1; i >= 0; i--)
        if (ifl_q[i].inst == inst) ifl_q.delete(i);
    end else begin
      if (haz && m_cnt[inst] < 65535) m_cnt[inst]++;
      for (int i = ifl_q.size() - 1; i >= 0; i--) begin
        if (ifl_q[i].inst == inst) begin
          ifl_q[i].age++;
          if (flush || ifl_q[i].age >= depth_of(inst)) ifl_q.delete(i);
        end
      end
      if (!flush && id_valid && id_wb_en && !haz && id_dest != 0)
        ifl_q.push_back('{inst, id_dest, id_mem_read, 0});
    end
  endtask

  task automatic cycle(input bit v, input logic [4:0] s1, input logic [4:0] s2,
                       input bit two, input logic [4:0] d, input bit wb, input bit ld,
                       input bit fl, input bit r);
    logic [17:0] e;
    id_valid = v; src1 = s1; src2 = s2; two_src = two; id_dest = d;
    id_wb_en = wb; id_mem_read = ld; flush = fl; rst = r;
    model_step(0, e); exp_q0.push_back(e);
    model_step(1, e); exp_q1.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic check(input int inst, input logic [17:0] exp_v, input logic [17:0] act_v);
    n_vec++;
    if (act_v !== exp_v) begin
      n_miss++;
      $display("FAIL d%0d_out t=%0t act haz=%b pend=%b cnt=%0d exp haz=%b pend=%b cnt=%0d",
               depth_of(inst), $time, act_v[17], act_v[16], act_v[15:0],
               exp_v[17], exp_v[16], exp_v[15:0]);
    end
  endtask

  always @(negedge clk) begin
    logic [17:0] e;
    if (exp_q0.size() > 0) begin
      e = exp_q0.pop_front();
      check(0, e, {haz0, pend0, cnt0});
    end
    if (exp_q1.size() > 0) begin
      e = exp_q1.pop_front();
      check(1, e, {haz1, pend1, cnt1});
    end
  end

  initial begin
    id_valid = 0; src1 = 0; src2 = 0; two_src = 0; id_dest = 0;
    id_wb_en = 0; id_mem_read = 0; flush = 0; rst = 1;
    m_cnt[0] = 0; m_cnt[1] = 0;
    repeat (2) @(posedge clk);
    #1;

    // Checked reset cycle, then writer r3 followed by a reader of r3.
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 1);
    cycle(1, 0, 0, 0, 3, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(1, 3, 0, 0, 0, 0, 0, 0, 0);
    idle(8);
    // Writer of r0 is never tracked.
    cycle(1, 0, 0, 0, 0, 1, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(8);
    // Load r5 then src2 reader; then the same with a non-load.
    cycle(1, 0, 0, 0, 5, 1, 1, 0, 0);
    for (int i = 0; i < 3; i++) cycle(1, 0, 5, 1, 0, 0, 0, 0, 0);
    idle(8);
    cycle(1, 0, 0, 0, 5, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(1, 0, 5, 1, 0, 0, 0, 0, 0);
    idle(8);
    // src2 matches but is not read.
    cycle(1, 0, 0, 0, 7, 1, 1, 0, 0);
    cycle(1, 0, 7, 0, 0, 0, 0, 0, 0);
    idle(8);
    // Flush in the middle of a stall.
    cycle(1, 0, 0, 0, 4, 1, 1, 0, 0);
    cycle(1, 4, 0, 0, 0, 0, 0, 0, 0);
    cycle(1, 4, 0, 0, 0, 0, 0, 1, 0);
    cycle(1, 4, 0, 0, 0, 0, 0, 0, 0);
    idle(2);
    // Reset arriving mid-stall.
    cycle(1, 0, 0, 0, 6, 1, 1, 0, 0);
    cycle(1, 6, 0, 0, 0, 0, 0, 0, 0);
    cycle(1, 6, 0, 0, 0, 0, 0, 0, 1);
    cycle(1, 6, 0, 0, 0, 0, 0, 0, 0);
    idle(2);

    // Random traffic over a small register space to provoke matches.
    for (int i = 0; i < 1500; i++) begin
      cycle(($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            $urandom_range(0, 1), 5'($urandom_range(0, 7)), ($urandom_range(0, 4) != 0),
            $urandom_range(0, 1), ($urandom_range(0, 15) == 0), ($urandom_range(0, 99) == 0));
    end

    // Saturate the counter: one load of r3 then eight dependent cycles per round.
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int r = 0; r < 8250; r++) begin
      cycle(1, 0, 0, 0, 3, 1, 1, 0, 0);
      for (int i = 0; i < 8; i++) cycle(1, 3, 0, 0, 0, 0, 0, 0, 0);
    end
    cycle(1, 3, 0, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(3);

    repeat (4) @(negedge clk);
    if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
      n_miss++;
      $display("FAIL drain act=%0d/%0d required=0/0", exp_q0.size(), exp_q1.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
